sram_responder: RTL and testbench
=================================

# sram_responder

Synthesizable responder for the external 256K×16 asynchronous SRAM pin interface driven by the data-memory SRAM controller. It decodes the controller's active-low strobes, performs byte-laned writes into an internal array, and returns read data on the shared bidirectional data bus after a programmable latency. It sits at the far end of the SRAM pins, in place of the physical device, for on-chip emulation and for closed-loop simulation of the memory stage with freeze timing.

## Interface
Parameters:
- ADDR_W, 18, address width; array depth is 2**ADDR_W words of 16 bits
- READ_LAT, 2, clock edges from first sampled read to valid data; legal range 1..7

Ports:
- clk  input  1  rising-edge clock, same clock as the controller
- rst  input  1  asynchronous, active-high reset
- SRAM_DQ  inout  16  shared data bus; driven only in DRIVE state, otherwise high-Z
- SRAM_ADDR  input  ADDR_W  word address
- SRAM_UB_N  input  1  upper byte lane enable, active low (DQ[15:8])
- SRAM_LB_N  input  1  lower byte lane enable, active low (DQ[7:0])
- SRAM_WE_N  input  1  write enable, active low
- SRAM_CE_N  input  1  chip enable, active low
- SRAM_OE_N  input  1  output enable, active low
- rd_valid  output  1  registered; high while DQ carries valid read data
- wr_pulse  output  1  registered; one-cycle pulse after each committed write edge

## Operation
- Each rising edge classifies sampled pins: WRITE = CE_N=0 & WE_N=0 (WE_N low dominates OE_N); READ = CE_N=0 & WE_N=1 & OE_N=0; otherwise NOP.
- WRITE: at that edge, mem[ADDR][15:8] <= DQ[15:8] if UB_N=0; mem[ADDR][7:0] <= DQ[7:0] if LB_N=0. Both lanes disabled: no array change, wr_pulse stays 0. wr_pulse=1 next cycle otherwise. Consecutive WRITE edges each commit.
- Read FSM, states IDLE, WAIT, DRIVE:
  - IDLE: READ edge -> latch rd_addr=ADDR, cnt=READ_LAT-1, go WAIT.
  - WAIT: READ edge with ADDR==rd_addr: cnt==0 -> load dout=mem[rd_addr], go DRIVE; else cnt-1. READ with different ADDR: relatch, reload cnt, stay WAIT. NOP or WRITE: go IDLE.
  - DRIVE: READ edge with same ADDR: reload dout (tracks array), stay. Different ADDR: relatch, go WAIT. NOP or WRITE: go IDLE.
- DQ drive enable is combinational: state==DRIVE & CE_N=0 & OE_N=0 & WE_N=1; per lane additionally gated by UB_N/LB_N low. Disabled lanes high-Z.
- rd_valid = (state==DRIVE), registered.
- Address arithmetic: ADDR used as-is, no wrap logic beyond ADDR_W truncation.

## Timing
- Reset (async): state IDLE, cnt 0, rd_addr 0, dout 0, rd_valid 0, wr_pulse 0, DQ high-Z immediately. Array contents not reset.
- Reset asserted mid-read: DQ released in same cycle; next read restarts full latency.
- Read latency: READ first sampled at edge k -> DQ valid and rd_valid=1 from edge k+READ_LAT while READ and address held.
- DQ release: combinational on CE_N/OE_N rising or WE_N falling; rd_valid falls one edge later.
- Write-then-read same address: WRITE at edge k, READ from edge k+1 returns new data at edge k+1+READ_LAT.
- Lane-disable during DRIVE releases only that lane, no state change.

## Structure
- Package sram_pkg: state enum (IDLE, WAIT, DRIVE), DQ_W=16, lane index constants, READ_LAT bounds.
- Sub-module sram_byte_array: 2**ADDR_W×16 storage with two byte write enables and one read port; top holds FSM, counter, tri-state drivers.

## Test plan
- Reset: assert rst mid-DRIVE -> DQ high-Z same cycle, rd_valid=0, state IDLE; after release, fresh read takes READ_LAT edges.
- Full write/read: write 16'hA5C3 to 18'h00010 (both lanes), then READ held -> DQ=16'hA5C3, rd_valid exactly READ_LAT edges after first read edge.
- Byte lanes: preload 16'h1234 at 18'h00020; write 16'hFFEE with UB_N=1, LB_N=0 -> read 16'h12EE; read with LB_N=1 -> DQ[7:0] high-Z.
- Address change: READ 18'h00010 in DRIVE, switch to 18'h00011 -> rd_valid drops next edge, new data after READ_LAT; mid-WAIT change restarts count.
- Controller pairing (READ_LAT=2): 32-bit store 32'hDEADBEEF then load via controller -> value=32'hDEADBEEF, freeze released, no DQ contention (responder never drives while WE_N=0).
- No-lane write: WE_N=0, UB_N=LB_N=1 -> array unchanged, wr_pulse stays 0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM pin-level responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sram_pkg;

    localparam int DQ_W   = 16;
    localparam int BYTE_W = 8;

    // Byte lane bit positions on the data bus
    localparam int LANE_HI_MSB = 15;
    localparam int LANE_HI_LSB = 8;
    localparam int LANE_LO_MSB = 7;
    localparam int LANE_LO_LSB = 0;

    // Legal read latency range and the width of the countdown that implements it
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 7;
    localparam int CNT_W        = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sram_byte_array.sv
// Word-addressed 16-bit storage with independent upper/lower byte write enables.
// Latency: writes commit on the clock edge; read port is combinational.
// Backpressure: none; every enabled write edge is accepted.
module sram_byte_array
    import sram_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DQ_W-1:0]   wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DQ_W-1:0]   rd_dat
);

    logic [DQ_W-1:0] mem [2**ADDR_W];

    // Byte-laned write; contents are deliberately not reset, like the real device
    always_ff @(posedge clk) begin
        if (we_hi) begin
            mem[wr_addr][LANE_HI_MSB:LANE_HI_LSB] <= wr_dat[LANE_HI_MSB:LANE_HI_LSB];
        end
        if (we_lo) begin
            mem[wr_addr][LANE_LO_MSB:LANE_LO_LSB] <= wr_dat[LANE_LO_MSB:LANE_LO_LSB];
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/sram_responder.sv
// Emulates an async 16-bit SRAM at the pins: byte-laned writes, reads returned on shared DQ.
// Latency: write commits at the sampled edge; read data valid READ_LAT edges after first READ edge.
// Backpressure: none; DQ is released combinationally when CE_N/OE_N rise or WE_N falls.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DQ_W-1:0]   SRAM_DQ,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    output logic              rd_valid,
    output logic              wr_pulse
);

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
        $error("sram_responder: READ_LAT must be within 1..7");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

    rd_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DQ_W-1:0]   dout_q;
    logic [DQ_W-1:0]   arr_rd_dat;
    logic              dout_load;

    logic is_write, is_read, same_addr;
    logic we_hi, we_lo;
    logic drive_en;

    // WE_N low wins over OE_N, so a write cycle is never also a read cycle
    assign is_write  = !SRAM_CE_N && !SRAM_WE_N;
    assign is_read   = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;
    assign same_addr = (SRAM_ADDR == rd_addr_q);
    assign we_hi     = is_write && !SRAM_UB_N;
    assign we_lo     = is_write && !SRAM_LB_N;

    sram_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we_hi   (we_hi),
        .we_lo   (we_lo),
        .wr_addr (SRAM_ADDR),
        .wr_dat  (SRAM_DQ),
        .rd_addr (rd_addr_q),
        .rd_dat  (arr_rd_dat)
    );

    // Read sequencing: count down latency on a held address, then keep refreshing output data
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        dout_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_read) begin
                    rd_addr_d = SRAM_ADDR;
                    cnt_d     = CNT_LOAD;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (!is_read) begin
                    state_d = IDLE;
                end else if (!same_addr) begin
                    rd_addr_d = SRAM_ADDR;
                    cnt_d     = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    dout_load = 1'b1;
                    state_d   = DRIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DRIVE: begin
                if (!is_read) begin
                    state_d = IDLE;
                end else if (same_addr) begin
                    dout_load = 1'b1;
                end else begin
                    rd_addr_d = SRAM_ADDR;
                    cnt_d     = CNT_LOAD;
                    state_d   = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latency counter, latched address and output data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            if (dout_load) begin
                dout_q <= arr_rd_dat;
            end
        end
    end

    // Status flags: rd_valid mirrors DRIVE, wr_pulse marks an edge that changed the array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            wr_pulse <= 1'b0;
        end else begin
            rd_valid <= (state_d == DRIVE);
            wr_pulse <= we_hi || we_lo;
        end
    end

    // Drive only while the pins still request a read, so a falling WE_N can never collide
    assign drive_en = (state_q == DRIVE) && is_read;

    assign SRAM_DQ[LANE_HI_MSB:LANE_HI_LSB] = (drive_en && !SRAM_UB_N) ?
        dout_q[LANE_HI_MSB:LANE_HI_LSB] : {BYTE_W{1'bz}};
    assign SRAM_DQ[LANE_LO_MSB:LANE_LO_LSB] = (drive_en && !SRAM_LB_N) ?
        dout_q[LANE_LO_MSB:LANE_LO_LSB] : {BYTE_W{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Directed plus randomized bench for sram_responder against a cycle-level behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_responder;

    localparam int ADDR_W   = 18;
    localparam int READ_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    wire  [15:0]       dq;
    logic [15:0]       tb_dq;
    logic              tb_dq_oe;
    logic [ADDR_W-1:0] addr;
    logic              ub_n, lb_n, we_n, ce_n, oe_n;
    logic              rd_valid, wr_pulse;

    int checks = 0;
    int errors = 0;

    // Model state: sparse memory image and length of the current same-address read run
    logic [15:0]       ref_mem [logic [ADDR_W-1:0]];
    int                run_len;
    logic [ADDR_W-1:0] run_addr;
    logic              exp_wr_pulse;

    // Released bus bits float high, so "high-Z" reads back as 1s
    assign dq = tb_dq_oe ? tb_dq : 16'bz;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (dq[i]);
    end

    always #5 clk = ~clk;

    sram_responder #(
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SRAM_DQ   (dq),
        .SRAM_ADDR (addr),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .SRAM_WE_N (we_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .rd_valid  (rd_valid),
        .wr_pulse  (wr_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus value the pins should show given the model and the current strobes
    function automatic logic [15:0] exp_dq();
        logic [15:0] v;
        logic [15:0] m;
        v = 16'hFFFF;
        if (run_len > READ_LAT && !ce_n && we_n && !oe_n) begin
            m = ref_mem[run_addr];
            if (!ub_n) v[15:8] = m[15:8];
            if (!lb_n) v[7:0]  = m[7:0];
        end
        return v;
    endfunction

    // Apply the sampled pins to the model at a clock edge
    task automatic model_edge();
        logic        is_wr, is_rd;
        logic [15:0] w;
        is_wr = !ce_n && !we_n;
        is_rd = !ce_n && we_n && !oe_n;
        exp_wr_pulse = is_wr && (!ub_n || !lb_n);
        if (is_wr && (!ub_n || !lb_n)) begin
            w = ref_mem.exists(addr) ? ref_mem[addr] : 16'h0000;
            if (!ub_n) w[15:8] = tb_dq[15:8];
            if (!lb_n) w[7:0]  = tb_dq[7:0];
            ref_mem[addr] = w;
        end
        if (is_rd) begin
            if (run_len > 0 && addr == run_addr) begin
                run_len++;
            end else begin
                run_len  = 1;
                run_addr = addr;
            end
        end else begin
            run_len = 0;
        end
    endtask

    // One bus cycle: set pins, take an edge, compare outputs against the model
    task automatic step(input logic ce, input logic we, input logic oe, input logic ub,
                        input logic lb, input logic [ADDR_W-1:0] a, input logic [15:0] d);
        ce_n = ce; we_n = we; oe_n = oe; ub_n = ub; lb_n = lb; addr = a; tb_dq = d;
        tb_dq_oe = !ce && !we;
        @(posedge clk);
        model_edge();
        #1;
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, (run_len > READ_LAT)});
        chk("wr_pulse", {31'd0, wr_pulse}, {31'd0, exp_wr_pulse});
        if (!tb_dq_oe) chk("dq", {16'd0, dq}, {16'd0, exp_dq()});
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic ub, input logic lb);
        step(1'b0, 1'b0, 1'b1, ub, lb, a, d);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic ub, input logic lb);
        step(1'b0, 1'b1, 1'b0, ub, lb, a, 16'h0000);
    endtask

    task automatic nop();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 16'h0000);
    endtask

    int          first_valid;
    logic [15:0] word_hi, word_lo;
    logic [ADDR_W-1:0] cur;
    int          r;

    initial begin
        rst = 1'b1;
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
        addr = '0; tb_dq = 16'h0000; tb_dq_oe = 1'b0;
        run_len = 0; run_addr = '0; exp_wr_pulse = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_wr_pulse", {31'd0, wr_pulse}, 32'd0);
        chk("reset_dq", {16'd0, dq}, 32'h0000_FFFF);
        rst = 1'b0;

        // Full-word write then held read, with explicit latency measurement
        wr(18'h00010, 16'hA5C3, 1'b0, 1'b0);
        first_valid = -1;
        for (int k = 1; k <= 5; k++) begin
            rd(18'h00010, 1'b0, 1'b0);
            if (rd_valid && first_valid < 0) first_valid = k;
        end
        chk("read_latency", first_valid, READ_LAT + 1);
        chk("read_full", {16'd0, dq}, 32'h0000_A5C3);

        // OE_N rising releases DQ immediately; rd_valid drops one edge later
        oe_n = 1'b1;
        #1;
        chk("oe_release_dq", {16'd0, dq}, 32'h0000_FFFF);
        chk("oe_release_valid_held", {31'd0, rd_valid}, 32'd1);
        nop();

        // Byte lanes: upper lane masked write, then lower-lane-disabled read
        wr(18'h00020, 16'h1234, 1'b0, 1'b0);
        wr(18'h00020, 16'hFFEE, 1'b1, 1'b0);
        repeat (4) rd(18'h00020, 1'b0, 1'b0);
        chk("lane_merge", {16'd0, dq}, 32'h0000_12EE);
        repeat (2) rd(18'h00020, 1'b0, 1'b1);
        chk("lane_lo_released", {16'd0, dq}, 32'h0000_12FF);
        rd(18'h00020, 1'b1, 1'b0);
        nop();

        // Address change during DRIVE, then mid-WAIT change restarting the count
        wr(18'h00011, 16'h5A0F, 1'b0, 1'b0);
        repeat (4) rd(18'h00010, 1'b0, 1'b0);
        repeat (4) rd(18'h00011, 1'b0, 1'b0);
        rd(18'h00010, 1'b0, 1'b0);
        repeat (4) rd(18'h00011, 1'b0, 1'b0);
        chk("addr_change_data", {16'd0, dq}, 32'h0000_5A0F);
        nop();

        // Write with both lanes disabled changes nothing
        wr(18'h00020, 16'h0000, 1'b1, 1'b1);
        repeat (4) rd(18'h00020, 1'b0, 1'b0);
        chk("nolane_unchanged", {16'd0, dq}, 32'h0000_12EE);
        nop();

        // 32-bit store/load as two halfwords, back-to-back with no idle between phases
        wr(18'h00030, 16'hDEAD, 1'b0, 1'b0);
        wr(18'h00031, 16'hBEEF, 1'b0, 1'b0);
        repeat (4) rd(18'h00030, 1'b0, 1'b0);
        word_hi = dq;
        repeat (4) rd(18'h00031, 1'b0, 1'b0);
        word_lo = dq;
        chk("load32", {word_hi, word_lo}, 32'hDEADBEEF);
        wr(18'h00032, 16'h0102, 1'b0, 1'b0);

        // Reset in the middle of DRIVE, then a fresh read takes the full latency
        repeat (4) rd(18'h00010, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_dq", {16'd0, dq}, 32'h0000_FFFF);
        chk("rst_mid_valid", {31'd0, rd_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_len = 0;
        first_valid = -1;
        for (int k = 1; k <= 5; k++) begin
            rd(18'h00010, 1'b0, 1'b0);
            if (rd_valid && first_valid < 0) first_valid = k;
        end
        chk("rst_restart_latency", first_valid, READ_LAT + 1);
        nop();

        // Randomized traffic over a small initialised address pool
        for (int i = 0; i < 4; i++) wr(18'h00040 + 18'(i), 16'($urandom), 1'b0, 1'b0);
        cur = 18'h00040;
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     18'h00040 + 18'($urandom_range(0, 3)), 16'($urandom));
            end else if (r <= 2) begin
                cur = 18'h00040 + 18'($urandom_range(0, 3));
                step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), cur, 16'($urandom));
            end else begin
                if ($urandom_range(0, 4) == 0) cur = 18'h00040 + 18'($urandom_range(0, 3));
                rd(cur, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
